// File: rtl/cpu_pipe_ctrl_pkg.sv
// Shared helpers for the in-order pipeline controller.
package cpu_pipe_ctrl_pkg;

  // Highest stage index whose pending write can still be seen as a RAW hazard.
  // A write-before-read register file hides a writeback-stage match.
  function automatic int unsigned hazard_last_stage(input int unsigned depth,
                                                    input int unsigned wb_bypass);
    return (wb_bypass != 0) ? depth - 2 : depth - 1;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-stage valid/rd/we shift chain with the decode-stage RAW hazard compare.
module pipe_scoreboard
  import cpu_pipe_ctrl_pkg::*;
#(
  parameter int unsigned RADDR_W   = 3,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned WB_BYPASS = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [RADDR_W-1:0] i_rs_a,
  input  logic [RADDR_W-1:0] i_rs_b,
  input  logic               i_rs_a_used,
  input  logic               i_rs_b_used,
  input  logic [RADDR_W-1:0] i_rd,
  input  logic               i_rd_we,
  output logic               o_hazard,
  output logic [DEPTH-1:0]   o_valid,
  output logic               o_wb_we,
  output logic [RADDR_W-1:0] o_wb_addr
);

  localparam int unsigned LastChk = hazard_last_stage(DEPTH, WB_BYPASS);

  // Stage 0 destination comes straight from the decode inputs, so only 1.. are stored.
  logic [DEPTH-1:0]   r_valid;
  logic [DEPTH-1:1]   r_we;
  logic [RADDR_W-1:0] r_rd [DEPTH-1:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_we    <= '0;
      for (int k = 1; k < DEPTH; k++) r_rd[k] <= '0;
    end else begin
      for (int k = 2; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_we[k]    <= r_we[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
      // A stall holds stage 0 and injects a bubble behind it.
      r_valid[1] <= r_valid[0] & ~i_stall;
      r_we[1]    <= i_rd_we & ~i_stall;
      r_rd[1]    <= i_rd;
      if (!i_stall) r_valid[0] <= ~i_flush;
    end
  end

  always_comb begin
    o_hazard = 1'b0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (k <= LastChk && r_valid[k] && r_we[k]) begin
        if ((i_rs_a_used && r_rd[k] == i_rs_a) || (i_rs_b_used && r_rd[k] == i_rs_b)) begin
          o_hazard = 1'b1;
        end
      end
    end
    o_hazard = o_hazard & r_valid[0];
  end

  assign o_valid   = r_valid;
  assign o_wb_we   = r_valid[DEPTH-1] & r_we[DEPTH-1];
  assign o_wb_addr = r_rd[DEPTH-1];

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// Fetch PC, interlock and branch-flush control for a short in-order pipeline.
module cpu_pipe_ctrl
  import cpu_pipe_ctrl_pkg::*;
#(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned RADDR_W   = 3,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned WB_BYPASS = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    pc,
  output logic               fd_en,
  input  logic [RADDR_W-1:0] rs_a,
  input  logic [RADDR_W-1:0] rs_b,
  input  logic               rs_a_used,
  input  logic               rs_b_used,
  input  logic [RADDR_W-1:0] rd,
  input  logic               rd_we,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               stall,
  output logic               flush,
  output logic [DEPTH-1:0]   stage_valid,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_addr
);

  logic [PC_W-1:0] r_pc;
  logic            w_hazard;
  logic            w_stall;
  logic            w_flush;

  // Reset wins over both interlock and redirect in the same cycle.
  assign w_stall = w_hazard & ~reset;
  assign w_flush = stage_valid[0] & br_taken & ~w_stall & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
    end else if (w_flush) begin
      r_pc <= br_target;
    end else if (!w_stall) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  pipe_scoreboard #(
    .RADDR_W  (RADDR_W),
    .DEPTH    (DEPTH),
    .WB_BYPASS(WB_BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_stall    (w_stall),
    .i_flush    (w_flush),
    .i_rs_a     (rs_a),
    .i_rs_b     (rs_b),
    .i_rs_a_used(rs_a_used),
    .i_rs_b_used(rs_b_used),
    .i_rd       (rd),
    .i_rd_we    (rd_we),
    .o_hazard   (w_hazard),
    .o_valid    (stage_valid),
    .o_wb_we    (wb_we),
    .o_wb_addr  (wb_addr)
  );

  assign pc    = r_pc;
  assign fd_en = ~w_stall;
  assign stall = w_stall;
  assign flush = w_flush;

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Bench for cpu_pipe_ctrl: directed vector table, corner sequences, random vs. reference model.
module tb_cpu_pipe_ctrl;

  localparam int PC_W    = 8;
  localparam int RADDR_W = 3;
  localparam int DEPTH   = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [RADDR_W-1:0] rs_a, rs_b, rd;
  logic               rs_a_used, rs_b_used, rd_we, br_taken;
  logic [PC_W-1:0]    br_target;

  // Index 0: WB_BYPASS=0, index 1: WB_BYPASS=1
  logic [PC_W-1:0]    pc      [2];
  logic               fd_en   [2];
  logic               stall   [2];
  logic               flush   [2];
  logic [DEPTH-1:0]   sv      [2];
  logic               wb_we   [2];
  logic [RADDR_W-1:0] wb_addr [2];

  int n_chk  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cpu_pipe_ctrl #(
      .PC_W     (PC_W),
      .RADDR_W  (RADDR_W),
      .DEPTH    (DEPTH),
      .WB_BYPASS(g)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc[g]),
      .fd_en      (fd_en[g]),
      .rs_a       (rs_a),
      .rs_b       (rs_b),
      .rs_a_used  (rs_a_used),
      .rs_b_used  (rs_b_used),
      .rd         (rd),
      .rd_we      (rd_we),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .stall      (stall[g]),
      .flush      (flush[g]),
      .stage_valid(sv[g]),
      .wb_we      (wb_we[g]),
      .wb_addr    (wb_addr[g])
    );
  end

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [2:0] a, input logic au, input logic [2:0] b,
                        input logic bu, input logic [2:0] d, input logic dwe,
                        input logic br, input logic [7:0] tgt);
    rs_a = a; rs_a_used = au; rs_b = b; rs_b_used = bu;
    rd = d; rd_we = dwe; br_taken = br; br_target = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: list of in-flight instructions indexed by stage.
  bit       mv  [2][DEPTH];
  bit       mwe [2][DEPTH];
  bit [2:0] mrd [2][DEPTH];
  int       mpc [2];

  task automatic m_clear();
    for (int i = 0; i < 2; i++) begin
      mpc[i] = 0;
      for (int k = 0; k < DEPTH; k++) begin
        mv[i][k] = 0; mwe[i][k] = 0; mrd[i][k] = 0;
      end
    end
  endtask

  function automatic bit m_hazard(input int i);
    int lim = (i == 1) ? DEPTH - 2 : DEPTH - 1;
    if (!mv[i][0]) return 0;
    for (int k = 1; k <= lim; k++)
      if (mv[i][k] && mwe[i][k] &&
          ((rs_a_used && mrd[i][k] == rs_a) || (rs_b_used && mrd[i][k] == rs_b)))
        return 1;
    return 0;
  endfunction

  task automatic m_step(input int i, input bit st, input bit fl);
    if (reset) begin
      mpc[i] = 0;
      for (int k = 0; k < DEPTH; k++) begin
        mv[i][k] = 0; mwe[i][k] = 0; mrd[i][k] = 0;
      end
      return;
    end
    for (int k = DEPTH - 1; k >= 2; k--) begin
      mv[i][k] = mv[i][k-1]; mwe[i][k] = mwe[i][k-1]; mrd[i][k] = mrd[i][k-1];
    end
    if (st) begin
      mv[i][1] = 0; mwe[i][1] = 0;
    end else begin
      mv[i][1] = mv[i][0]; mwe[i][1] = rd_we; mrd[i][1] = rd;
      mv[i][0] = !fl;
      mpc[i] = fl ? int'(br_target) : (mpc[i] + 1) % 256;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    m_clear();
  endtask

  typedef struct {
    logic [2:0] rs_a; logic au; logic [2:0] rs_b; logic bu;
    logic [2:0] rd; logic we; logic br; logic [7:0] tgt;
    logic [7:0] e_pc; logic e_stall; logic e_flush; logic [2:0] e_valid;
    logic e_wb; logic [2:0] e_wba; logic chk_b; logic e_stall_b;
  } vec_t;

  vec_t tbl[14];

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    m_clear();

    //          rs_a au rs_b bu rd we br tgt    pc   st fl valid  wb wba cb sb
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 3'b000, 0, 0, 1, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 3'b001, 0, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0, 3'b011, 0, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 3'b111, 0, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 2, 1, 0, 8'h00, 8'h04, 0, 0, 3'b111, 0, 0, 1, 0};
    tbl[5]  = '{2, 1, 0, 0, 0, 0, 0, 8'h00, 8'h05, 1, 0, 3'b111, 0, 0, 1, 1};
    tbl[6]  = '{2, 1, 0, 0, 0, 0, 0, 8'h00, 8'h05, 1, 0, 3'b101, 1, 2, 1, 0};
    tbl[7]  = '{2, 1, 0, 0, 0, 0, 0, 8'h00, 8'h05, 0, 0, 3'b001, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 3, 1, 0, 8'h00, 8'h06, 0, 0, 3'b011, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 3, 1, 0, 0, 1, 8'h40, 8'h07, 1, 0, 3'b111, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 3, 1, 0, 0, 1, 8'h40, 8'h07, 1, 0, 3'b101, 1, 3, 0, 0};
    tbl[11] = '{0, 0, 3, 1, 0, 0, 1, 8'h40, 8'h07, 0, 1, 3'b001, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 8'h40, 8'h40, 0, 0, 3'b010, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h41, 0, 0, 3'b101, 0, 0, 0, 0};

    do_reset();
    for (int r = 0; r < 14; r++) begin
      set_in(tbl[r].rs_a, tbl[r].au, tbl[r].rs_b, tbl[r].bu, tbl[r].rd, tbl[r].we,
             tbl[r].br, tbl[r].tgt);
      @(negedge clk);
      chk($sformatf("tbl%0d pc", r), 32'(pc[0]), 32'(tbl[r].e_pc));
      chk($sformatf("tbl%0d stall", r), 32'(stall[0]), 32'(tbl[r].e_stall));
      chk($sformatf("tbl%0d fd_en", r), 32'(fd_en[0]), 32'(!tbl[r].e_stall));
      chk($sformatf("tbl%0d flush", r), 32'(flush[0]), 32'(tbl[r].e_flush));
      chk($sformatf("tbl%0d valid", r), 32'(sv[0]), 32'(tbl[r].e_valid));
      chk($sformatf("tbl%0d wb_we", r), 32'(wb_we[0]), 32'(tbl[r].e_wb));
      if (tbl[r].e_wb) chk($sformatf("tbl%0d wb_addr", r), 32'(wb_addr[0]), 32'(tbl[r].e_wba));
      if (tbl[r].chk_b) chk($sformatf("tbl%0d bypass stall", r), 32'(stall[1]),
                            32'(tbl[r].e_stall_b));
      step();
    end

    // Taken branch at pc 0x10, then wrap through 0xFF.
    do_reset();
    for (int c = 0; c < 16; c++) step();
    set_in(0, 0, 0, 0, 0, 0, 1, 8'h40);
    @(negedge clk);
    chk("br pc", 32'(pc[0]), 32'h10);
    chk("br flush", 32'(flush[0]), 32'd1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 1, 8'hFF);
    @(negedge clk);
    chk("br target pc", 32'(pc[0]), 32'h40);
    chk("br squash v0", 32'(sv[0][0]), 32'd0);
    chk("br in stage1", 32'(sv[0][1]), 32'd1);
    chk("br ignored when v0=0", 32'(flush[0]), 32'd0);
    step();
    @(negedge clk);
    chk("br2 flush", 32'(flush[0]), 32'd1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pc at ff", 32'(pc[0]), 32'hFF);
    step();
    @(negedge clk);
    chk("pc wrap", 32'(pc[0]), 32'h00);
    step();

    // Reset asserted in the middle of a stall.
    do_reset();
    step();
    step();
    set_in(0, 0, 0, 0, 2, 1, 0, 0);
    step();
    set_in(2, 1, 0, 0, 0, 0, 1, 8'h20);
    @(negedge clk);
    chk("pre-reset stall", 32'(stall[0]), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst pc", 32'(pc[0]), 32'd0);
    chk("rst valid", 32'(sv[0]), 32'd0);
    chk("rst stall", 32'(stall[0]), 32'd0);
    chk("rst flush", 32'(flush[0]), 32'd0);
    chk("rst wb_we", 32'(wb_we[0]), 32'd0);
    chk("rst fd_en", 32'(fd_en[0]), 32'd1);
    step();

    // Random traffic against the reference model, both bypass settings.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_in(3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
             3'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 5) == 0),
             8'($urandom));
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit h, f;
        logic [DEPTH-1:0] ev;
        h = m_hazard(i);
        f = mv[i][0] && br_taken && !h;
        for (int k = 0; k < DEPTH; k++) ev[k] = mv[i][k];
        if (!reset) begin
          chk($sformatf("rnd%0d[%0d] stall", c, i), 32'(stall[i]), 32'(h));
          chk($sformatf("rnd%0d[%0d] flush", c, i), 32'(flush[i]), 32'(f));
          chk($sformatf("rnd%0d[%0d] fd_en", c, i), 32'(fd_en[i]), 32'(!h));
          chk($sformatf("rnd%0d[%0d] pc", c, i), 32'(pc[i]), 32'(mpc[i]));
          chk($sformatf("rnd%0d[%0d] valid", c, i), 32'(sv[i]), 32'(ev));
          chk($sformatf("rnd%0d[%0d] wb_we", c, i), 32'(wb_we[i]),
              32'(mv[i][DEPTH-1] && mwe[i][DEPTH-1]));
          if (mv[i][DEPTH-1] && mwe[i][DEPTH-1])
            chk($sformatf("rnd%0d[%0d] wb_addr", c, i), 32'(wb_addr[i]),
                32'(mrd[i][DEPTH-1]));
        end
        m_step(i, h, f);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
